// File: rtl/even_sample_buffer_pkg.sv
// =============================================================================
// Module      : even_sample_buffer_pkg
// Description : Shared widths and sizing helpers for the even sample buffer.
// Revision    : 1.0
// =============================================================================
`default_nettype none

package even_sample_buffer_pkg;

   localparam int DEFAULT_WIDTH = 32;

   // Pointer index width; never narrower than one bit.
   function automatic int ptr_width(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

   // Occupancy must represent 0..depth inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/even_sample_buffer_sync_fifo_core.sv
// =============================================================================
// Module      : sync_fifo_core
// Description : Count-based synchronous FIFO with a registered head.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module sync_fifo_core
   import even_sample_buffer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en,
   input  logic [WIDTH-1:0]              wr_data,
   input  logic                          rd_en,
   output logic [WIDTH-1:0]              rd_data,
   output logic                          rd_valid,
   output logic [count_width(DEPTH)-1:0] count,
   output logic                          push
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = count_width(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    rd_ptr_nxt;
   logic [CW-1:0]    count_nxt;
   logic [WIDTH-1:0] head_nxt;
   logic             full;
   logic             pop;

   always_comb begin
      full       = (count == DEPTH_C);
      pop        = rd_valid & rd_en;
      push       = wr_en & (~full | pop);
      rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;
      count_nxt  = count;
      if (push && !pop) begin
         count_nxt = count + CW'(1);
      end else if (pop && !push) begin
         count_nxt = count - CW'(1);
      end
      // The next head is either the entry being written now or one already stored.
      head_nxt = '0;
      if (count_nxt != '0) begin
         if (push && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = wr_data;
         end else begin
            head_nxt = mem[rd_ptr_nxt];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         rd_ptr   <= rd_ptr_nxt;
         count    <= count_nxt;
         rd_valid <= (count_nxt != '0);
         rd_data  <= head_nxt;
      end
   end

   a_count_bound : assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_C);
   a_valid_count : assert property (@(posedge clk) disable iff (!rst_n) rd_valid == (count != '0));

endmodule

`default_nettype wire

// File: rtl/even_sample_buffer.sv
// =============================================================================
// Module      : even_sample_buffer
// Description : Keeps even samples: last-even register, FIFO, sticky overflow.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module even_sample_buffer
   import even_sample_buffer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic [WIDTH-1:0]              last_even,
   output logic [count_width(DEPTH)-1:0] count,
   output logic                          overflow,
   input  logic                          clr_overflow
);

   logic even;
   logic push;
   logic drop;

   always_comb begin
      even = in_valid & ~in_data[0];
      drop = even & ~push;
   end

   sync_fifo_core #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (even),
      .wr_data  (in_data),
      .rd_en    (out_ready),
      .rd_data  (out_data),
      .rd_valid (out_valid),
      .count    (count),
      .push     (push)
   );

   // Dropped samples still update last_even; a drop beats a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_even <= '0;
         overflow  <= 1'b0;
      end else begin
         if (even) begin
            last_even <= in_data;
         end
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

   a_out_even  : assert property (@(posedge clk) disable iff (!rst_n) out_data[0] == 1'b0);
   a_last_even : assert property (@(posedge clk) disable iff (!rst_n) last_even[0] == 1'b0);

endmodule

`default_nettype wire
